fb_write_ctrl: RTL and testbench
================================

# fb_write_ctrl

- Sits directly downstream of the SPI receive buffer, in the CLK domain.
- Consumes its 16-bit word stream plus the Mode flag: Mode=0 is a command, Mode=1 is data.
- Decodes display-style window commands (CASET/PASET/RAMWR) and turns pixel data words into sequential frame-buffer RAM writes inside the programmed window.
- Back-pressures the SPI buffer whenever the RAM write port stalls.

## Interface
Parameters:
- H_RES, 320, frame width in pixels
- V_RES, 240, frame height in lines
- ADDR_W, 17, RAM word-address width (≥ clog2(H_RES·V_RES))

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-high reset
- i_Data  in  16  word from SPI buffer
- i_Mode  in  1  0 = command (low byte is the opcode), 1 = data
- i_valid  in  1  i_Data/i_Mode valid
- o_ready  out  1  block accepts the word this cycle
- o_RAM_we  out  1  write request valid
- o_RAM_addr  out  ADDR_W  pixel address = row·H_RES + col
- o_RAM_data  out  16  RGB565 pixel
- i_RAM_ready  in  1  RAM accepts the write this cycle
- o_win_done  out  1  one-cycle pulse when the last pixel of the window is issued

## Operation
- **Transfer rule:** a word transfers on a CLK edge where i_valid && o_ready.
- **Commands** (Mode=0), decoded from i_Data[7:0]:
  - 0x2A CASET → state COL_S
  - 0x2B PASET → state ROW_S
  - 0x2C RAMWR → state WRITE; loads col=col_start, row=row_start, addr=row_start·H_RES+col_start
  - any other opcode → IDLE
  - A command is legal in every state and aborts the current sequence.
- **CASET/PASET parameters:**
  - COL_S: data word → col_start, then COL_E.
  - COL_E: data word → col_end, then IDLE.
  - ROW_S/ROW_E behave the same for rows.
- **Clamping:**
  - Values ≥ H_RES (cols) or ≥ V_RES (rows) clamp to H_RES−1 / V_RES−1.
  - If end < start after clamping, end := start.
- **Data in IDLE:** data words are accepted and dropped.
- **Pixel writes (WRITE state):** each data word issues one write at the current addr, then advances:
  - col < col_end: col+1, addr+1.
  - otherwise col=col_start, and line_base += H_RES, except at row_end where row=row_start and line_base=row_start·H_RES; addr = line_base + col_start.
  - Writing the pixel at (col_end,row_end) pulses o_win_done, wraps to (col_start,row_start), and stays in WRITE.
- **Multiplication:** row·H_RES is computed only on RAMWR entry and wrap, as a constant multiply (320 = shift 8 + shift 6). No general multiplier.
- **Reset state:**
  - Outputs: o_RAM_we=0, o_RAM_addr=0, o_RAM_data=0, o_win_done=0, o_ready=0 while RST is high.
  - State IDLE; window 0..H_RES−1 × 0..V_RES−1.

## Timing
- **Latency:** a pixel accepted at edge N appears with o_RAM_we=1 after edge N. It is held stable until the edge where i_RAM_ready=1.
- **Ready rule:** o_ready = !RST && (!o_RAM_we || i_RAM_ready).
  - This is a one-entry output register with pass-through ready, so there are no bubbles at full rate.
  - The same rule applies in every state, so commands also wait behind a stalled write.
- **Simultaneous events:** a write retires and a new pixel is accepted on the same edge → o_RAM_we stays 1 with the new addr/data.
- **o_win_done:** asserted in the cycle after the last-pixel acceptance edge, for exactly one cycle, independent of i_RAM_ready.
- **Mid-operation reset:** RST mid-write drops o_RAM_we immediately (asynchronously). The pending write is lost and the window returns to full screen.
- **Mid-window RAMWR:** restarts at (col_start,row_start).

## Structure
- Package fb_pkg holds:
  - The opcode constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C.
  - The state enum {IDLE, COL_S, COL_E, ROW_S, ROW_E, WRITE}.
  - The H_RES/V_RES defaults.
- One sub-module, fb_addr_gen, holds col/row/line_base/addr.
  - Inputs: load, step, and window bounds.
  - Outputs: addr and a last-pixel flag.
- The FSM and the output register stay in fb_write_ctrl.

## Test plan
- Reset, then RAMWR, then 3 pixels 0xF800,0x07E0,0x001F with i_RAM_ready=1 → writes at addr 0,1,2; o_ready never drops.
- CASET 10,12; PASET 5,6; RAMWR; 6 pixels → addrs 1610,1611,1612,1930,1931,1932. o_win_done pulses after the 6th; a 7th pixel writes at 1610.
- CASET 400,300 → window col 319..319. RAMWR; 2 pixels → addrs 319,639.
- i_RAM_ready held 0 for 5 cycles during a pixel stream → o_ready=0 for those cycles; addr/data stable; no pixel lost or duplicated.
- Data words 0x1234 in IDLE, then RAMWR + 1 pixel → only one write, at addr 0. A CASET sent mid-WRITE aborts the stream; its data words set the window.
- RST asserted while o_RAM_we=1 → o_RAM_we=0 in the same cycle. After release, RAMWR writes at addr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared opcodes, controller states and default frame geometry for the
// frame-buffer write path.
package fb_pkg;

    localparam int H_RES_DEFAULT = 320;
    localparam int V_RES_DEFAULT = 240;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        COL_S,
        COL_E,
        ROW_S,
        ROW_E,
        WRITE
    } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Walks the programmed window in raster order and produces the RAM word
// address of the current pixel plus a flag marking the window's last pixel.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEFAULT,
    parameter int V_RES  = V_RES_DEFAULT,
    parameter int ADDR_W = 17,
    parameter int COL_W  = $clog2(H_RES),
    parameter int ROW_W  = $clog2(V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [COL_W-1:0]  col_start,
    input  logic [COL_W-1:0]  col_end,
    input  logic [ROW_W-1:0]  row_start,
    input  logic [ROW_W-1:0]  row_end,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] start_base;
    logic [ADDR_W-1:0] col_start_ext;

    // Constant multiply by H_RES built from the set bits of H_RES, so only
    // shifted copies of the row are summed (320 -> row<<8 + row<<6).
    function automatic logic [ADDR_W-1:0] times_hres(input logic [ROW_W-1:0] r);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (H_RES[i]) begin
                acc = acc + (ADDR_W'(r) << i);
            end
        end
        return acc;
    endfunction

    assign start_base    = times_hres(row_start);
    assign col_start_ext = ADDR_W'(col_start);
    assign last          = (col == col_end) && (row == row_end);

    // Line base is only re-derived from the row on load and on window wrap;
    // every other line step is a plain add of H_RES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            addr      <= '0;
        end else if (load) begin
            col       <= col_start;
            row       <= row_start;
            line_base <= start_base;
            addr      <= start_base + col_start_ext;
        end else if (step) begin
            if (col < col_end) begin
                col  <= col + 1'b1;
                addr <= addr + 1'b1;
            end else begin
                col <= col_start;
                if (row == row_end) begin
                    row       <= row_start;
                    line_base <= start_base;
                    addr      <= start_base + col_start_ext;
                end else begin
                    row       <= row + 1'b1;
                    line_base <= line_base + ADDR_W'(H_RES);
                    addr      <= line_base + ADDR_W'(H_RES) + col_start_ext;
                end
            end
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Decodes CASET/PASET/RAMWR window commands from the SPI word stream and
// turns pixel data into frame-buffer writes through a one-entry output register.
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEFAULT,
    parameter int V_RES  = V_RES_DEFAULT,
    parameter int ADDR_W = 17
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       i_Data,
    input  logic              i_Mode,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_RAM_we,
    output logic [ADDR_W-1:0] o_RAM_addr,
    output logic [15:0]       o_RAM_data,
    input  logic              i_RAM_ready,
    output logic              o_win_done
);

    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);

    state_t            state;
    logic [COL_W-1:0]  col_start;
    logic [COL_W-1:0]  col_end;
    logic [ROW_W-1:0]  row_start;
    logic [ROW_W-1:0]  row_end;
    logic [COL_W-1:0]  col_in;
    logic [ROW_W-1:0]  row_in;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;
    logic              accept;
    logic              cmd_take;
    logic              data_take;
    logic              pixel_take;
    logic              load;

    function automatic logic [COL_W-1:0] clamp_col(input logic [15:0] v);
        if (v >= 16'(H_RES)) begin
            return COL_W'(H_RES - 1);
        end
        return v[COL_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] clamp_row(input logic [15:0] v);
        if (v >= 16'(V_RES)) begin
            return ROW_W'(V_RES - 1);
        end
        return v[ROW_W-1:0];
    endfunction

    // Pass-through ready: a new word may enter whenever the output slot is
    // empty or is being drained this very cycle.
    assign o_ready    = !RST && (!o_RAM_we || i_RAM_ready);
    assign accept     = i_valid && o_ready;
    assign cmd_take   = accept && !i_Mode;
    assign data_take  = accept && i_Mode;
    assign pixel_take = data_take && (state == WRITE);
    assign load       = cmd_take && (i_Data[7:0] == CMD_RAMWR);
    assign col_in     = clamp_col(i_Data);
    assign row_in     = clamp_row(i_Data);

    fb_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_addr_gen (
        .clk       (CLK),
        .rst       (RST),
        .load      (load),
        .step      (pixel_take),
        .col_start (col_start),
        .col_end   (col_end),
        .row_start (row_start),
        .row_end   (row_end),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    // Command decode, window parameter capture and the output write register.
    // Commands abort whatever sequence is in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            col_start  <= '0;
            col_end    <= COL_W'(H_RES - 1);
            row_start  <= '0;
            row_end    <= ROW_W'(V_RES - 1);
            o_RAM_we   <= 1'b0;
            o_RAM_addr <= '0;
            o_RAM_data <= '0;
            o_win_done <= 1'b0;
        end else begin
            o_win_done <= pixel_take && gen_last;

            if (pixel_take) begin
                o_RAM_we   <= 1'b1;
                o_RAM_addr <= gen_addr;
                o_RAM_data <= i_Data;
            end else if (i_RAM_ready) begin
                o_RAM_we <= 1'b0;
            end

            if (cmd_take) begin
                case (i_Data[7:0])
                    CMD_CASET: state <= COL_S;
                    CMD_PASET: state <= ROW_S;
                    CMD_RAMWR: state <= WRITE;
                    default:   state <= IDLE;
                endcase
            end else if (data_take) begin
                case (state)
                    COL_S: begin
                        col_start <= col_in;
                        state     <= COL_E;
                    end
                    COL_E: begin
                        col_end <= (col_in < col_start) ? col_start : col_in;
                        state   <= IDLE;
                    end
                    ROW_S: begin
                        row_start <= row_in;
                        state     <= ROW_E;
                    end
                    ROW_E: begin
                        row_end <= (row_in < row_start) ? row_start : row_in;
                        state   <= IDLE;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: directed scenarios plus randomized
// windows, all checked against a window/scoreboard model kept in the bench.
module tb_fb_write_ctrl;

    localparam int H_RES  = 320;
    localparam int V_RES  = 240;
    localparam int ADDR_W = 17;

    localparam int M_IDLE  = 0;
    localparam int M_COL_S = 1;
    localparam int M_COL_E = 2;
    localparam int M_ROW_S = 3;
    localparam int M_ROW_E = 4;
    localparam int M_WRITE = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic [15:0]       i_Data;
    logic              i_Mode;
    logic              i_valid;
    logic              i_RAM_ready;
    logic              o_ready;
    logic              o_RAM_we;
    logic [ADDR_W-1:0] o_RAM_addr;
    logic [15:0]       o_RAM_data;
    logic              o_win_done;

    int checks = 0;
    int errors = 0;

    int mState, cs, ce, rs, re, col, row;
    int pendAddr[$];
    int pendData[$];
    bit expDone;

    always #10 CLK = ~CLK;

    fb_write_ctrl #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_Data      (i_Data),
        .i_Mode      (i_Mode),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_RAM_we    (o_RAM_we),
        .o_RAM_addr  (o_RAM_addr),
        .o_RAM_data  (o_RAM_data),
        .i_RAM_ready (i_RAM_ready),
        .o_win_done  (o_win_done)
    );

    function automatic int clampV(int v, int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mState = M_IDLE;
        cs = 0; ce = H_RES - 1;
        rs = 0; re = V_RES - 1;
        col = 0; row = 0;
        pendAddr.delete();
        pendData.delete();
        expDone = 0;
    endtask

    // Window/raster model: one pending write slot, positions kept as plain
    // column/row numbers and addresses formed as row*H_RES+col.
    task automatic modelStep(bit acc);
        int d;
        expDone = 0;
        if (pendAddr.size() > 0 && i_RAM_ready) begin
            void'(pendAddr.pop_front());
            void'(pendData.pop_front());
        end
        if (!acc) return;
        d = int'(i_Data);
        if (!i_Mode) begin
            case (d & 8'hFF)
                8'h2A:   mState = M_COL_S;
                8'h2B:   mState = M_ROW_S;
                8'h2C:   begin mState = M_WRITE; col = cs; row = rs; end
                default: mState = M_IDLE;
            endcase
        end else begin
            case (mState)
                M_COL_S: begin cs = clampV(d, H_RES); mState = M_COL_E; end
                M_COL_E: begin ce = clampV(d, H_RES); if (ce < cs) ce = cs; mState = M_IDLE; end
                M_ROW_S: begin rs = clampV(d, V_RES); mState = M_ROW_E; end
                M_ROW_E: begin re = clampV(d, V_RES); if (re < rs) re = rs; mState = M_IDLE; end
                M_WRITE: begin
                    pendAddr.push_back(row * H_RES + col);
                    pendData.push_back(d);
                    if (col == ce && row == re) begin
                        expDone = 1;
                        col = cs;
                        row = rs;
                    end else if (col < ce) begin
                        col++;
                    end else begin
                        col = cs;
                        if (row == re) row = rs;
                        else row++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus: drive, compare outputs on the falling edge,
    // then advance the model across the rising edge.
    task automatic applyStimulus(bit v, bit m, logic [15:0] d, bit rr, output bit accepted);
        bit expWe;
        bit expReady;
        i_valid = v; i_Mode = m; i_Data = d; i_RAM_ready = rr;
        @(negedge CLK);
        expWe    = pendAddr.size() > 0;
        expReady = !RST && (!expWe || rr);
        checkOutput("ready", o_ready, expReady);
        checkOutput("we", o_RAM_we, expWe);
        if (expWe) begin
            checkOutput("addr", o_RAM_addr, pendAddr[0]);
            checkOutput("data", o_RAM_data, pendData[0]);
        end
        checkOutput("win_done", o_win_done, expDone);
        accepted = v && expReady;
        @(posedge CLK);
        modelStep(accepted);
        #1;
    endtask

    task automatic sendWord(bit m, logic [15:0] d, int stallPct);
        bit acc;
        bit rr;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) begin
            rr = ($urandom_range(99) >= stallPct) || (i > 20);
            applyStimulus(1'b1, m, d, rr, acc);
        end
        checkOutput("send_accepted", acc, 1);
    endtask

    task automatic idleCycles(int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, acc);
    endtask

    task automatic setWindow(int c0, int c1, int r0, int r1, int stallPct);
        sendWord(1'b0, 16'h002A, stallPct);
        sendWord(1'b1, 16'(c0), stallPct);
        sendWord(1'b1, 16'(c1), stallPct);
        sendWord(1'b0, 16'h002B, stallPct);
        sendWord(1'b1, 16'(r0), stallPct);
        sendWord(1'b1, 16'(r1), stallPct);
    endtask

    initial begin
        bit acc;
        int c0, r0, n;
        RST = 1'b1; i_valid = 1'b0; i_Mode = 1'b0; i_Data = '0; i_RAM_ready = 1'b0;
        modelReset();
        #5;
        checkOutput("reset_we", o_RAM_we, 0);
        checkOutput("reset_addr", o_RAM_addr, 0);
        checkOutput("reset_data", o_RAM_data, 0);
        checkOutput("reset_done", o_win_done, 0);
        checkOutput("reset_ready", o_ready, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        $display("[TB] full-screen RAMWR, three pixels");
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'hF800, 0);
        checkOutput("plan1_addr0", o_RAM_addr, 0);
        sendWord(1'b1, 16'h07E0, 0);
        sendWord(1'b1, 16'h001F, 0);
        checkOutput("plan1_addr2", o_RAM_addr, 2);
        idleCycles(2);

        $display("[TB] window 10..12 x 5..6 with wrap");
        setWindow(10, 12, 5, 6, 0);
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'h1111, 0);
        checkOutput("plan2_first", o_RAM_addr, 1610);
        for (int i = 0; i < 4; i++) sendWord(1'b1, 16'(16'h2000 + i), 0);
        checkOutput("plan2_fifth", o_RAM_addr, 1931);
        sendWord(1'b1, 16'h3333, 0);
        checkOutput("plan2_sixth", o_RAM_addr, 1932);
        sendWord(1'b1, 16'h4444, 0);
        checkOutput("plan2_wrap", o_RAM_addr, 1610);
        idleCycles(2);

        $display("[TB] clamped column window");
        setWindow(400, 300, 0, 239, 0);
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'hAAAA, 0);
        checkOutput("clamp_first", o_RAM_addr, 319);
        sendWord(1'b1, 16'h5555, 0);
        checkOutput("clamp_second", o_RAM_addr, 639);
        idleCycles(2);

        $display("[TB] RAM stall for five cycles");
        setWindow(0, 319, 0, 239, 0);
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'hBEEF, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'hCAFE, 1'b0, acc);
        sendWord(1'b1, 16'hCAFE, 0);
        sendWord(1'b1, 16'hF00D, 0);
        idleCycles(2);

        $display("[TB] IDLE data dropped, CASET aborts a stream");
        sendWord(1'b0, 16'h0000, 0);
        sendWord(1'b1, 16'h1234, 0);
        sendWord(1'b1, 16'h1234, 0);
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'h0101, 0);
        sendWord(1'b1, 16'h0202, 0);
        sendWord(1'b0, 16'h002A, 0);
        sendWord(1'b1, 16'd3, 0);
        sendWord(1'b1, 16'd5, 0);
        sendWord(1'b0, 16'h002C, 0);
        for (int i = 0; i < 4; i++) sendWord(1'b1, 16'(16'h0300 + i), 0);
        idleCycles(2);

        $display("[TB] randomized windows with RAM stalls");
        for (int w = 0; w < 8; w++) begin
            c0 = $urandom_range(330);
            r0 = $urandom_range(250);
            setWindow(c0, c0 + $urandom_range(4), r0, r0 + $urandom_range(3), 30);
            if ($urandom_range(1)) sendWord(1'b1, 16'($urandom), 30);
            sendWord(1'b0, 16'h002C, 30);
            n = $urandom_range(25, 3);
            for (int p = 0; p < n; p++) begin
                sendWord(1'b1, 16'($urandom), 30);
                if ($urandom_range(9) == 0) sendWord(1'b0, 16'h002C, 30);
            end
            idleCycles($urandom_range(3));
        end
        idleCycles(2);

        $display("[TB] reset while a write is pending");
        sendWord(1'b0, 16'h002A, 0);
        sendWord(1'b1, 16'd7, 0);
        sendWord(1'b1, 16'd9, 0);
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'h7777, 0);
        i_valid = 1'b0; i_RAM_ready = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        checkOutput("rst_async_we", o_RAM_we, 0);
        checkOutput("rst_async_ready", o_ready, 0);
        modelReset();
        applyStimulus(1'b1, 1'b1, 16'h9999, 1'b1, acc);
        RST = 1'b0;
        sendWord(1'b0, 16'h002C, 0);
        sendWord(1'b1, 16'h8888, 0);
        checkOutput("post_reset_addr", o_RAM_addr, 0);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
